// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory arbiter slice.
// DATA_W is the machine word; the DEF_* values are the default build.
package dmem_pkg;

  localparam int DATA_W     = 16;
  localparam int DEF_NCORES = 2;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_ADDR_W = 8;

  // Index width for n items, never below 1 so a single-core build still has a pointer.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from the index after i_last,
// wrapping, and returns the first eligible requester.
module rr_arbiter
  import dmem_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    int j;
    j       = 0;
    o_gnt   = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    // i_last itself is visited last, which is what gives it lowest priority.
    for (int i = 1; i <= N; i++) begin
      j = (int'(i_last) + i) % N;
      if (!o_valid && i_elig[j]) begin
        o_valid  = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-ported word memory shared by NCORES core data ports; one
// round-robin-arbitrated access per clock, each acknowledged with a DRDY pulse.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NCORES = DEF_NCORES,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NCORES-1:0]          MEMREAD,
  input  logic [NCORES-1:0]          MEMWR,
  input  logic [DATA_W*NCORES-1:0]   DMADDR,
  input  logic [DATA_W*NCORES-1:0]   DOUT,
  output logic [DATA_W*NCORES-1:0]   DIN,
  output logic [NCORES-1:0]          DRDY
);

  localparam int PTR_W = clog2(NCORES);

  // Handshake: a core holds MEMREAD/MEMWR, DMADDR and DOUT until it sees its
  // DRDY; DRDY[k] high means the access completed on the previous edge.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_din [NCORES];
  logic [NCORES-1:0] r_drdy;
  logic [PTR_W-1:0]  r_last;

  logic [NCORES-1:0] w_elig;
  logic [NCORES-1:0] w_gnt;
  logic              w_valid;
  logic [PTR_W-1:0]  w_idx;
  logic [ADDR_W-1:0] w_addr  [NCORES];
  logic [DATA_W-1:0] w_wdata [NCORES];
  logic [ADDR_W-1:0] w_gaddr;
  logic [DATA_W-1:0] w_gdata;
  logic              w_gwr;
  logic              w_unused_addr_hi;

  // A core in its own DRDY cycle is masked so a held request is not served twice.
  assign w_elig = (MEMREAD | MEMWR) & ~r_drdy;

  for (genvar k = 0; k < NCORES; k++) begin : g_port
    assign w_addr[k]                   = DMADDR[DATA_W*k +: ADDR_W];
    assign w_wdata[k]                  = DOUT[DATA_W*k +: DATA_W];
    assign DIN[DATA_W*k +: DATA_W]     = r_din[k];
  end

  // Address bits above ADDR_W are don't-care: accesses wrap modulo DEPTH.
  assign w_unused_addr_hi = ^DMADDR;

  rr_arbiter #(.N(NCORES)) u_rr (
    .i_elig  (w_elig),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_gaddr = w_addr[w_idx];
  assign w_gdata = w_wdata[w_idx];
  assign w_gwr   = MEMWR[w_idx];
  assign DRDY    = r_drdy;

  // Memory is not reset, but no write may land while reset is held.
  always_ff @(posedge clk) begin
    if (rstn && w_valid && w_gwr) begin
      r_mem[w_gaddr] <= w_gdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NCORES; k++) r_din[k] <= '0;
      r_drdy <= '0;
      r_last <= PTR_W'(NCORES - 1);
    end else begin
      r_drdy <= w_gnt;
      if (w_valid) begin
        r_last <= w_idx;
        if (!w_gwr) begin
          r_din[w_idx] <= r_mem[w_gaddr];
        end
      end
    end
  end

endmodule
